fir_output_conditioner: RTL and testbench
=========================================

// Module: fir_output_conditioner
// PURPOSE
//  Downstream stage of the FIR filter. Takes the 32-bit signed filter_out stream,
//  decimates by DECIM, rounds away SHIFT LSBs, saturates to OUT_W bits and buffers
//  results in a small FIFO with a valid/ready output handshake.
//  Sits between the FIR core and the sample sink (DAC/serializer); absorbs sink stalls.
// PARAMETERS
//  IN_W        32  width of signed input sample (FIR accumulator width)
//  OUT_W       16  width of signed output sample
//  SHIFT       2   LSBs discarded by rounding; 0 = no rounding, IN_W-OUT_W max
//  DECIM       4   decimation factor, >=1; DECIM=1 keeps every sample
//  FIFO_DEPTH  4   output FIFO entries, power of 2, >=2
// PORTS
//  clk         in   1                    rising-edge clock
//  reset_n     in   1                    asynchronous, active-low reset
//  in_valid    in   1                    in_data carries a new FIR output this cycle
//  in_data     in   IN_W                 signed FIR output sample
//  clr_flags   in   1                    synchronous clear of sat_flag/drop_flag
//  out_valid   out  1                    FIFO head is valid
//  out_ready   in   1                    sink accepts out_data this cycle
//  out_data    out  OUT_W                signed conditioned sample (FIFO head)
//  fifo_level  out  $clog2(FIFO_DEPTH)+1 entries currently held
//  sat_flag    out  1                    sticky: a kept sample was saturated
//  drop_flag   out  1                    sticky: a kept sample was lost (FIFO full)
// BEHAVIOUR
//  Reset (reset_n=0, async): out_valid=0, out_data=0, fifo_level=0, flags=0,
//   decimation counter=0, pipeline stage invalid; FIFO contents discarded at once.
//  Decimation: counter 0..DECIM-1 advances only on in_valid; sample is KEPT when
//   counter==DECIM-1 (counter wraps to 0). First kept sample = DECIM-th after reset.
//  Rounding: r = (in_data + 2^(SHIFT-1)) >>> SHIFT computed in IN_W+1 bits (no
//   overflow); round-half-up toward +inf; SHIFT=0 -> r = in_data.
//  Saturation: r clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; clamp sets sat_flag.
//  Pipeline: kept sample rounded/saturated into one register stage at edge t;
//   written to FIFO at edge t+1; out_valid rises after edge t+1 if FIFO was empty.
//   Latency in_valid(kept) -> out_valid = 2 cycles. Throughput 1 sample/cycle.
//  Handshake: pop when out_valid && out_ready. out_data/out_valid stable while
//   out_valid && !out_ready. out_data = 0 when FIFO empty.
//  FIFO write accepted when level<FIFO_DEPTH OR a pop occurs the same cycle
//   (full + simultaneous pop: write accepted, level unchanged, no drop).
//  Full and no pop: staged sample discarded, FIFO unchanged, drop_flag set.
//  Empty + write + out_ready: no fall-through; pop happens on following cycle.
//  Pointers wrap modulo FIFO_DEPTH; level = write count - read count, never > DEPTH.
//  Flags: set condition and clr_flags in same cycle -> flag set (set wins).
//  in_valid while reset_n=0 ignored; counter resumes from 0 after release.
// STRUCTURE
//  Shared package fir_pkg: OUT_W default, SAT_MAX/SAT_MIN constants, function
//   round_sat(in, shift) returning {sat, value} - reused by other FIR stages.
//  One sub-module: fir_out_fifo (sync FIFO, params WIDTH/DEPTH, push/pop/full/
//   empty/level, async active-low reset). Decimator, round/sat stage, flags in top.
// TESTING
//  1 Reset mid-stream: FIFO holding 3 entries, pulse reset_n low between edges ->
//    out_valid=0, fifo_level=0, flags=0 immediately; first kept sample DECIM later.
//  2 DECIM=4,SHIFT=2, in_data=16 every cycle, out_ready=1 -> out_data=4 once per
//    4 inputs, out_valid 2 cycles after each 4th in_valid.
//  3 DECIM=1,SHIFT=2 rounding: 6->2, 5->1, -6->-1, -7->-2, 0->0; sat_flag stays 0.
//  4 DECIM=1 saturation: 200000->32767, -200000->-32768, sat_flag=1; clr_flags
//    pulse -> 0; clr_flags together with new saturation -> stays 1.
//  5 Backpressure: out_ready=0, 5 kept samples 4,8,12,16,20 (pre-shift x4) ->
//    fifo_level=4, drop_flag=1; out_ready=1 -> outputs 4,8,12,16 in order, no 20.
//  6 FIFO full + pop and write in same cycle -> write accepted, level stays 4,
//    drop_flag stays 0; output order preserved.

Source files
------------

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the FIR filter output stages.
//   FIR_IN_W / FIR_OUT_W : accumulator width and conditioned sample width
//   SAT_MIN / SAT_MAX    : clamp limits for a FIR_OUT_W signed sample, held in
//                          the extended (FIR_IN_W+1) rounding width
//   round_sat()          : round-half-up by a variable shift, then clamp;
//                          returns {sat, value}
// -----------------------------------------------------------------------------
package fir_pkg;

  localparam int FIR_IN_W  = 32;
  localparam int FIR_OUT_W = 16;

  // One extra bit so adding the rounding bias can never overflow.
  typedef logic signed [FIR_IN_W:0]    fir_ext_t;
  typedef logic signed [FIR_OUT_W-1:0] fir_out_t;

  typedef struct packed {
    logic     sat;
    fir_out_t value;
  } fir_rs_t;

  localparam fir_ext_t SAT_MAX = fir_ext_t'((64'sd1 <<< (FIR_OUT_W - 1)) - 64'sd1);
  localparam fir_ext_t SAT_MIN = fir_ext_t'(-(64'sd1 <<< (FIR_OUT_W - 1)));

  // Round half up (toward +inf) by discarding 'shift' LSBs, then clamp to the
  // FIR_OUT_W signed range. shift = 0 passes the sample through unrounded.
  function automatic fir_rs_t round_sat(input logic signed [FIR_IN_W-1:0] sample,
                                        input int                         shift);
    fir_ext_t ext;
    fir_ext_t bias;
    fir_ext_t r;
    fir_rs_t  res;
    ext  = fir_ext_t'(sample);
    bias = (shift > 0) ? (fir_ext_t'(1) <<< (shift - 1)) : '0;
    r    = (ext + bias) >>> shift;
    res.sat   = 1'b0;
    res.value = r[FIR_OUT_W-1:0];
    if (r > SAT_MAX) begin
      res.sat   = 1'b1;
      res.value = SAT_MAX[FIR_OUT_W-1:0];
    end else if (r < SAT_MIN) begin
      res.sat   = 1'b1;
      res.value = SAT_MIN[FIR_OUT_W-1:0];
    end
    return res;
  endfunction

endpackage : fir_pkg

// File: rtl/fir_out_fifo.sv
// -----------------------------------------------------------------------------
// fir_out_fifo
// Synchronous FIFO holding conditioned output samples.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push_i       : write data_i (accepted when not full, or when a pop
//                  happens in the same cycle)
//   pop_i        : remove the head entry (ignored when empty)
//   data_i       : entry to write
//   data_o       : head entry, zero when empty
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
//   level_o      : number of entries held, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module fir_out_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q,  level_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LW'(DEPTH));

  // A pop frees a slot in the same cycle, so a full FIFO still takes a write
  // when the head leaves at the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule : fir_out_fifo

// File: rtl/fir_output_conditioner.sv
// -----------------------------------------------------------------------------
// fir_output_conditioner
// Downstream stage of the FIR filter: decimates the accumulator stream by
// DECIM, rounds away SHIFT LSBs (half up), saturates to OUT_W bits and queues
// the result in a small FIFO with a valid/ready output.
//   clk, reset_n : clock, asynchronous active-low reset
//   in_valid     : in_data carries a new FIR output this cycle
//   in_data      : signed FIR accumulator sample (IN_W)
//   clr_flags    : synchronous clear of sat_flag/drop_flag (a same-cycle set
//                  takes priority)
//   out_valid    : FIFO head is valid
//   out_ready    : sink takes out_data this cycle
//   out_data     : FIFO head (signed OUT_W), zero when empty
//   fifo_level   : entries currently held
//   sat_flag     : sticky, a kept sample was clamped
//   drop_flag    : sticky, a kept sample was lost because the FIFO was full
// IN_W/OUT_W must match the fir_pkg widths, since round_sat works on those.
// -----------------------------------------------------------------------------
module fir_output_conditioner
  import fir_pkg::*;
#(
  parameter  int IN_W       = FIR_IN_W,
  parameter  int OUT_W      = FIR_OUT_W,
  parameter  int SHIFT      = 2,
  parameter  int DECIM      = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    clr_flags,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [LVL_W-1:0]        fifo_level,
  output logic                    sat_flag,
  output logic                    drop_flag
);

  localparam int               CNT_W    = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

  // ---------------------------------------------------------------------------
  // Stage p0: decimation and round/saturate (combinational on the input)
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             keep_p0;
  fir_rs_t          rs_p0;

  // The counter only moves on in_valid; the DECIM-th valid sample is kept.
  assign keep_p0 = in_valid && (dec_cnt_q == CNT_LAST);

  always_comb begin
    dec_cnt_d = dec_cnt_q;
    if (in_valid) begin
      dec_cnt_d = keep_p0 ? '0 : dec_cnt_q + 1'b1;
    end
  end

  assign rs_p0 = round_sat(in_data, SHIFT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) dec_cnt_q <= '0;
    else          dec_cnt_q <= dec_cnt_d;
  end

  // ---------------------------------------------------------------------------
  // Stage p1: registered conditioned sample, pushed into the FIFO next edge
  // ---------------------------------------------------------------------------
  logic       vld_p1_q;
  fir_out_t   data_p1_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) vld_p1_q <= 1'b0;
    else          vld_p1_q <= keep_p0;
  end

  always_ff @(posedge clk) begin
    if (keep_p0) data_p1_q <= rs_p0.value;
  end

  // ---------------------------------------------------------------------------
  // Stage p2: output FIFO and handshake
  // ---------------------------------------------------------------------------
  logic             fifo_full;
  logic             fifo_empty;
  logic [OUT_W-1:0] fifo_dout;

  fir_out_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (vld_p1_q),
    .pop_i   (out_ready),
    .data_i  (data_p1_q),
    .data_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = fifo_dout;

  // ---------------------------------------------------------------------------
  // Sticky status flags
  // ---------------------------------------------------------------------------
  logic sat_set, drop_set;
  logic sat_q,   sat_d;
  logic drop_q,  drop_d;

  // Clamping is flagged when the sample is kept. A staged sample is lost only
  // when the FIFO is full and the head is not leaving (full implies valid).
  assign sat_set  = keep_p0 && rs_p0.sat;
  assign drop_set = vld_p1_q && fifo_full && !out_ready;

  always_comb begin
    sat_d  = sat_set  || (sat_q  && !clr_flags);
    drop_d = drop_set || (drop_q && !clr_flags);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      sat_q  <= sat_d;
      drop_q <= drop_d;
    end
  end

  assign sat_flag  = sat_q;
  assign drop_flag = drop_q;

endmodule : fir_output_conditioner

// File: tb/tb_fir_output_conditioner.sv
module tb_fir_output_conditioner;

  localparam int IN_W  = 32;
  localparam int OUT_W = 16;
  localparam int SHIFT = 2;
  localparam int DEPTH = 4;
  localparam int DEC0  = 4;
  localparam int DEC1  = 1;
  localparam longint SMAX = 32767;
  localparam longint SMIN = -32768;

  logic clk = 1'b0;
  logic reset_n;

  logic                    iv  [2];
  logic signed [IN_W-1:0]  id  [2];
  logic                    clr [2];
  logic                    rdy [2];
  logic                    ov  [2];
  logic signed [OUT_W-1:0] od  [2];
  logic [2:0]              lvl [2];
  logic                    sf  [2];
  logic                    df  [2];

  int checks   = 0;
  int failures = 0;

  // Reference model state, one set per DUT
  longint mq     [2][$];
  int     mcnt   [2];
  bit     mstg_v [2];
  longint mstg   [2];
  bit     msat   [2];
  bit     mdrop  [2];
  longint cap    [2][$];

  always #5 clk = ~clk;

  fir_output_conditioner #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DEC0), .FIFO_DEPTH(DEPTH)
  ) u_dut_d4 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[0]), .in_data(id[0]),
    .clr_flags(clr[0]), .out_valid(ov[0]), .out_ready(rdy[0]), .out_data(od[0]),
    .fifo_level(lvl[0]), .sat_flag(sf[0]), .drop_flag(df[0])
  );

  fir_output_conditioner #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .DECIM(DEC1), .FIFO_DEPTH(DEPTH)
  ) u_dut_d1 (
    .clk(clk), .reset_n(reset_n), .in_valid(iv[1]), .in_data(id[1]),
    .clr_flags(clr[1]), .out_valid(ov[1]), .out_ready(rdy[1]), .out_data(od[1]),
    .fifo_level(lvl[1]), .sat_flag(sf[1]), .drop_flag(df[1])
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dec_of(input int k);
    return (k == 0) ? DEC0 : DEC1;
  endfunction

  // Round half up by plain integer arithmetic: floor((x + 2^(S-1)) / 2^S)
  function automatic longint ref_round(input longint x);
    longint d, n;
    if (SHIFT == 0) return x;
    d = longint'(1) << SHIFT;
    n = x + d / 2;
    if (n >= 0) return n / d;
    return -((-n + d - 1) / d);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k].delete();
      mcnt[k]   = 0;
      mstg_v[k] = 0;
      mstg[k]   = 0;
      msat[k]   = 0;
      mdrop[k]  = 0;
    end
  endtask

  // What one rising edge does, given the inputs currently driven
  task automatic model_step(input int k);
    bit     pop, sat_set, drop_set;
    longint r;
    sat_set  = 0;
    drop_set = 0;
    pop = (mq[k].size() > 0) && rdy[k];
    if (pop) void'(mq[k].pop_front());
    if (mstg_v[k]) begin
      if (mq[k].size() < DEPTH) mq[k].push_back(mstg[k]);
      else drop_set = 1;
    end
    mstg_v[k] = 0;
    if (iv[k]) begin
      mcnt[k]++;
      if (mcnt[k] == dec_of(k)) begin
        mcnt[k]   = 0;
        mstg_v[k] = 1;
        r = ref_round(longint'(id[k]));
        if (r > SMAX)      begin mstg[k] = SMAX; sat_set = 1; end
        else if (r < SMIN) begin mstg[k] = SMIN; sat_set = 1; end
        else               mstg[k] = r;
      end
    end
    msat[k]  = sat_set  || (msat[k]  && !clr[k]);
    mdrop[k] = drop_set || (mdrop[k] && !clr[k]);
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("d%0d_valid", k), longint'(ov[k]), longint'(mq[k].size() > 0));
      chk($sformatf("d%0d_data", k), longint'(od[k]), (mq[k].size() > 0) ? mq[k][0] : 0);
      chk($sformatf("d%0d_level", k), longint'(lvl[k]), longint'(mq[k].size()));
      chk($sformatf("d%0d_sat", k), longint'(sf[k]), longint'(msat[k]));
      chk($sformatf("d%0d_drop", k), longint'(df[k]), longint'(mdrop[k]));
    end
  endtask

  // Called just after a falling edge with inputs set; advances one cycle
  task automatic tick();
    for (int k = 0; k < 2; k++) begin
      if (ov[k] && rdy[k]) cap[k].push_back(longint'(od[k]));
      model_step(k);
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input int k, input bit v, input longint d, input bit c, input bit r);
    iv[k]  = v;
    id[k]  = IN_W'(d);
    clr[k] = c;
    rdy[k] = r;
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, r);
      drive(1, 0, 0, 0, r);
      tick();
    end
  endtask

  task automatic clear_caps();
    cap[0].delete();
    cap[1].delete();
  endtask

  task automatic chk_caps(input int k, input string tag, input longint exp[$]);
    chk({tag, "_count"}, longint'(cap[k].size()), longint'(exp.size()));
    foreach (exp[i])
      chk($sformatf("%s_%0d", tag, i), (i < cap[k].size()) ? cap[k][i] : -999999, exp[i]);
  endtask

  // Asynchronous reset pulse between edges; outputs must clear at once
  task automatic reset_pulse();
    #1 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rst%0d_valid", k), longint'(ov[k]), 0);
      chk($sformatf("rst%0d_level", k), longint'(lvl[k]), 0);
      chk($sformatf("rst%0d_data", k), longint'(od[k]), 0);
      chk($sformatf("rst%0d_sat", k), longint'(sf[k]), 0);
      chk($sformatf("rst%0d_drop", k), longint'(df[k]), 0);
    end
    model_reset();
    #1 reset_n = 1'b1;
  endtask

  function automatic longint rand_sample();
    case ($urandom_range(0, 4))
      0: return longint'($urandom_range(0, 600)) - 300;
      1: return longint'(int'($urandom()));
      2: return (longint'($urandom_range(0, 16)) + 131064) * (($urandom_range(0, 1) != 0) ? 1 : -1);
      3: return ($urandom_range(0, 1) != 0) ? 64'sh7fffffff : -64'sh80000000;
      default: return longint'($urandom_range(0, 262144)) - 131072;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint e[$];
    int     n;

    // Reset held over several edges while in_valid is asserted
    reset_n = 1'b0;
    drive(0, 1, 123, 0, 1);
    drive(1, 1, 123, 0, 1);
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    reset_n = 1'b1;

    // DECIM=4: constant 16 -> 4 once per four inputs
    clear_caps();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 16, 0, 1);
      drive(1, 0, 0, 0, 1);
      tick();
    end
    idle(4, 1);
    e = '{4, 4, 4, 4};
    chk_caps(0, "dec4", e);

    // DECIM=1 rounding
    clear_caps();
    e = '{6, 5, -6, -7, 0};
    foreach (e[i]) begin
      drive(0, 0, 0, 0, 1);
      drive(1, 1, e[i], 0, 1);
      tick();
    end
    idle(4, 1);
    e = '{2, 1, -1, -2, 0};
    chk_caps(1, "round", e);
    chk("round_sat_flag", longint'(sf[1]), 0);

    // Saturation, flag clear, and set-wins-over-clear
    clear_caps();
    drive(0, 0, 0, 0, 1); drive(1, 1, 200000, 0, 1); tick();
    drive(0, 0, 0, 0, 1); drive(1, 1, -200000, 0, 1); tick();
    idle(4, 1);
    e = '{32767, -32768};
    chk_caps(1, "sat", e);
    chk("sat_flag_set", longint'(sf[1]), 1);
    drive(0, 0, 0, 0, 1); drive(1, 0, 0, 1, 1); tick();
    idle(1, 1);
    chk("sat_flag_clr", longint'(sf[1]), 0);
    drive(0, 0, 0, 0, 1); drive(1, 1, 200000, 1, 1); tick();
    chk("sat_set_wins", longint'(sf[1]), 1);
    idle(4, 1);

    // Backpressure: five kept samples into a four-entry FIFO
    drive(0, 0, 0, 0, 1); drive(1, 0, 0, 1, 1); tick();
    clear_caps();
    e = '{16, 32, 48, 64, 80};
    foreach (e[i]) begin
      drive(0, 0, 0, 0, 1);
      drive(1, 1, e[i], 0, 0);
      tick();
    end
    idle(3, 0);
    chk("bp_level", longint'(lvl[1]), 4);
    chk("bp_drop", longint'(df[1]), 1);
    idle(6, 1);
    e = '{4, 8, 12, 16};
    chk_caps(1, "bp", e);
    chk("bp_drained", longint'(lvl[1]), 0);

    // Full FIFO with pop and write in the same cycle
    drive(0, 0, 0, 0, 1); drive(1, 0, 0, 1, 1); tick();
    clear_caps();
    e = '{16, 32, 48, 64};
    foreach (e[i]) begin
      drive(0, 0, 0, 0, 1);
      drive(1, 1, e[i], 0, 0);
      tick();
    end
    idle(2, 0);
    chk("fp_full", longint'(lvl[1]), 4);
    drive(0, 0, 0, 0, 1); drive(1, 1, 80, 0, 0); tick();
    drive(0, 0, 0, 0, 1); drive(1, 1, 96, 0, 1); tick();
    chk("fp_level_a", longint'(lvl[1]), 4);
    drive(0, 0, 0, 0, 1); drive(1, 1, 112, 0, 1); tick();
    chk("fp_level_b", longint'(lvl[1]), 4);
    chk("fp_drop", longint'(df[1]), 0);
    idle(8, 1);
    e = '{4, 8, 12, 16, 20, 24, 28};
    chk_caps(1, "fp", e);

    // Mid-stream reset with three entries held in the DECIM=4 FIFO
    n = 0;
    while (mq[0].size() < 3 && n < 40) begin
      drive(0, 1, rand_sample(), 0, 0);
      drive(1, 1, rand_sample(), 0, 0);
      tick();
      n++;
    end
    chk("fill3_level", longint'(lvl[0]), 3);
    reset_pulse();
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 40, 0, 1);
      drive(1, 0, 0, 0, 1);
      tick();
    end
    idle(3, 1);

    // Randomized traffic, with phases of heavy and light backpressure
    for (int i = 0; i < 1500; i++) begin
      bit slow;
      slow = ((i / 250) % 2) == 1;
      for (int k = 0; k < 2; k++) begin
        drive(k, $urandom_range(0, 3) != 0, rand_sample(),
              $urandom_range(0, 19) == 0,
              slow ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
      end
      if (i == 700) reset_pulse();
      tick();
    end
    idle(10, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fir_output_conditioner
